// File: rtl/map_matrix_driver.sv
// map_matrix_driver: streams snapshot map rows to a shift-register LED matrix chain.
// Each row is one 16-bit word, sent MSB first and closed by a latch pulse.
module map_matrix_driver #(
  parameter int ROWS = 16,
  parameter int CLK_DIV = 50,
  parameter int BLINK_FRAMES = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [511:0] map_obstacles_flat,
  input  logic [511:0] map_objectives_flat,
  input  logic [3:0]   player_position,
  input  logic         game_over,
  output logic         sr_data,
  output logic         sr_clock,
  output logic         sr_latch,
  output logic         busy,
  output logic         frame_done,
  output logic [3:0]   db_row
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LOW, SHIFT_HIGH, LATCH, DONE} state_t;
  state_t state, nxt;
  logic [DW-1:0] div;
  logic [BW-1:0] blink_cnt;
  logic blink_phase;
  logic [3:0] row, bit_idx;
  logic [63:0] snap_obs, snap_obj;
  logic [3:0] snap_ply;
  logic snap_go;
  logic timed, tick, last_row;
  logic [3:0] obs, obj, ply;
  logic [11:0] pix;
  logic [15:0] word;
  logic unused_map;
  // Only the 16 addressable rows can ever be displayed.
  assign unused_map = ^{map_obstacles_flat[511:64], map_objectives_flat[511:64]};
  always_comb begin
    timed = state == SHIFT_LOW || state == SHIFT_HIGH || state == LATCH;
    tick = div == DW'(CLK_DIV - 1);
    last_row = row == 4'(ROWS - 1);
    obs = snap_obs[{row, 2'b00} +: 4];
    obj = blink_phase ? 4'b0 : snap_obj[{row, 2'b00} +: 4];
    ply = row == 4'd0 ? snap_ply : 4'b0;
    pix = snap_go && blink_phase ? 12'hFFF : {obs, obj, ply};
    word = {row, pix};
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = enable ? LOAD : IDLE;
      LOAD:       nxt = SHIFT_LOW;
      SHIFT_LOW:  nxt = tick ? SHIFT_HIGH : SHIFT_LOW;
      SHIFT_HIGH: nxt = !tick ? SHIFT_HIGH : bit_idx == 4'd0 ? LATCH : SHIFT_LOW;
      LATCH:      nxt = !tick ? LATCH : last_row ? DONE : SHIFT_LOW;
      DONE:       nxt = enable ? LOAD : IDLE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      div <= '0;
      row <= '0;
      bit_idx <= '0;
      snap_obs <= '0;
      snap_obj <= '0;
      snap_ply <= '0;
      snap_go <= 1'b0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      div <= timed && !tick ? div + 1'b1 : '0;
      if (state == LOAD) begin
        snap_obs <= map_obstacles_flat[63:0];
        snap_obj <= map_objectives_flat[63:0];
        snap_ply <= player_position;
        snap_go <= game_over;
        row <= '0;
        bit_idx <= 4'd15;
      end
      if (state == SHIFT_HIGH && tick && bit_idx != 4'd0) bit_idx <= bit_idx - 1'b1;
      if (state == LATCH && tick) begin
        bit_idx <= 4'd15;
        if (!last_row) row <= row + 1'b1;
      end
      // Row returns to 0 so an idle block shows all-zero outputs.
      if (state == DONE) begin
        row <= '0;
        blink_cnt <= blink_cnt == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt + 1'b1;
        blink_phase <= blink_cnt == BW'(BLINK_FRAMES - 1) ? !blink_phase : blink_phase;
      end
    end
  always_comb begin
    busy = state != IDLE;
    sr_clock = state == SHIFT_HIGH;
    sr_latch = state == LATCH;
    frame_done = state == DONE;
    sr_data = (state == SHIFT_LOW || state == SHIFT_HIGH) && word[bit_idx];
    db_row = row;
  end
endmodule

// File: tb/tb_map_matrix_driver.sv
// tb_map_matrix_driver: directed checks of frame format, blink, game-over, snapshot and reset.
module tb_map_matrix_driver;
  logic clock = 1'b0;
  logic reset_n, en_a, en_b, game_over;
  logic [511:0] obs_flat, obj_flat;
  logic [3:0] player;
  logic a_data, a_ck, a_la, a_busy, a_fd;
  logic b_data, b_ck, b_la, b_busy, b_fd;
  logic [3:0] a_row, b_row;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] a_words[$];
  logic [15:0] b_words[$];
  logic [15:0] a_sh = '0;
  logic [15:0] b_sh = '0;
  logic a_ck_q = 1'b0, a_la_q = 1'b0, b_ck_q = 1'b0, b_la_q = 1'b0;
  int a_la_cyc = 0;
  int b_la_cyc = 0;
  int base, lc, n, cyc, k;

  map_matrix_driver #(.ROWS(2), .CLK_DIV(2), .BLINK_FRAMES(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(en_a),
    .map_obstacles_flat(obs_flat), .map_objectives_flat(obj_flat),
    .player_position(player), .game_over(game_over),
    .sr_data(a_data), .sr_clock(a_ck), .sr_latch(a_la),
    .busy(a_busy), .frame_done(a_fd), .db_row(a_row)
  );

  map_matrix_driver #(.ROWS(16), .CLK_DIV(1), .BLINK_FRAMES(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(en_b),
    .map_obstacles_flat(obs_flat), .map_objectives_flat(obj_flat),
    .player_position(player), .game_over(1'b0),
    .sr_data(b_data), .sr_clock(b_ck), .sr_latch(b_la),
    .busy(b_busy), .frame_done(b_fd), .db_row(b_row)
  );

  always #5 clock = ~clock;

  // Emulates the external shift/storage registers, sampling between clock edges.
  always @(negedge clock) begin
    a_ck_q <= a_ck;
    a_la_q <= a_la;
    if (a_ck && !a_ck_q) a_sh <= {a_sh[14:0], a_data};
    if (a_la && !a_la_q) a_words.push_back(a_sh);
    if (a_la) a_la_cyc <= a_la_cyc + 1;
    b_ck_q <= b_ck;
    b_la_q <= b_la;
    if (b_ck && !b_ck_q) b_sh <= {b_sh[14:0], b_data};
    if (b_la && !b_la_q) b_words.push_back(b_sh);
    if (b_la) b_la_cyc <= b_la_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd_a(output int cnt);
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (!a_fd && cnt < 5000);
    check("fd_a_seen", a_fd, 1);
  endtask

  task automatic wait_fd_b(output int cnt);
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (!b_fd && cnt < 5000);
    check("fd_b_seen", b_fd, 1);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; en_a = 1'b0; en_b = 1'b0; game_over = 1'b0;
    obs_flat = '0; obj_flat = '0; player = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", a_busy, 0);
    check("rst_data", a_data, 0);
    check("rst_clk", a_ck, 0);
    check("rst_latch", a_la, 0);
    check("rst_fd", a_fd, 0);
    check("rst_row", a_row, 0);
    check("rst_b_busy", b_busy, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic frame: enable pulsed for one cycle
    obs_flat[3:0] = 4'b0010; obs_flat[7:4] = 4'b1000;
    obj_flat[7:4] = 4'b0001; player = 4'b0100;
    base = a_words.size(); lc = a_la_cyc;
    en_a = 1'b1;
    @(negedge clock);
    en_a = 1'b0;
    check("load_busy", a_busy, 1);
    cyc = 1;
    repeat (2) @(negedge clock);
    cyc += 2;
    check("low_phase_clk", a_ck, 0);
    @(negedge clock);
    cyc++;
    check("first_rise", a_ck, 1);
    wait_fd_a(n);
    check("frame_len", cyc + n, 134);
    check("basic_cnt", a_words.size(), base + 2);
    check("basic_w0", a_words[base], 16'h0204);
    check("basic_w1", a_words[base + 1], 16'h1810);
    check("latch_cycles", a_la_cyc - lc, 4);
    @(negedge clock);
    check("idle_busy", a_busy, 0);
    check("fd_one_cycle", a_fd, 0);

    // Blink with enable held, then enable drop plus snapshot change in frame 4
    pulse_reset();
    base = a_words.size();
    en_a = 1'b1;
    wait_fd_a(n);
    check("f1_len", n, 134);
    wait_fd_a(n);
    check("b2b_len", n, 134);
    wait_fd_a(n);
    repeat (20) @(negedge clock);
    check("mid_row0", a_row, 0);
    en_a = 1'b0;
    obs_flat[3:0] = 4'b1111;
    wait_fd_a(n);
    check("drop_finish", n, 114);
    @(negedge clock);
    check("drop_idle", a_busy, 0);
    check("drop_fd_once", a_fd, 0);
    check("blink_cnt", a_words.size(), base + 8);
    check("blink_f1r1", a_words[base + 1], 16'h1810);
    check("blink_f2r0", a_words[base + 2], 16'h0204);
    check("blink_f2r1", a_words[base + 3], 16'h1800);
    check("blink_f3r1", a_words[base + 5], 16'h1810);
    check("snap_f4r0", a_words[base + 6], 16'h0204);
    check("blink_f4r1", a_words[base + 7], 16'h1800);
    en_a = 1'b1;
    @(negedge clock);
    en_a = 1'b0;
    wait_fd_a(n);
    check("snap_f5r0", a_words[base + 8], 16'h0F04);
    check("snap_f5r1", a_words[base + 9], 16'h1810);
    obs_flat[3:0] = 4'b0010;
    @(negedge clock);

    // Game over flashing
    pulse_reset();
    base = a_words.size();
    game_over = 1'b1;
    en_a = 1'b1;
    wait_fd_a(n);
    wait_fd_a(n);
    en_a = 1'b0;
    @(negedge clock);
    check("go_idle", a_busy, 0);
    game_over = 1'b0;
    check("go_f1r0", a_words[base], 16'h0204);
    check("go_f1r1", a_words[base + 1], 16'h1810);
    check("go_f2r0", a_words[base + 2], 16'h0FFF);
    check("go_f2r1", a_words[base + 3], 16'h1FFF);

    // Asynchronous reset while shifting row 1 with sr_clock and sr_data high
    base = a_words.size();
    en_a = 1'b1;
    k = 0;
    while (!(a_row == 4'd1 && a_ck && a_data) && k < 500) begin
      @(negedge clock);
      k++;
    end
    check("midshift_found", k < 500, 1);
    en_a = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_data", a_data, 0);
    check("arst_clk", a_ck, 0);
    check("arst_latch", a_la, 0);
    check("arst_busy", a_busy, 0);
    check("arst_row", a_row, 0);
    repeat (3) @(negedge clock);
    check("arst_no_latch", a_words.size(), base + 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Full-size instance: 16 rows, CLK_DIV=1
    obs_flat[63:0] = 64'h1234_5678_9ABC_DEF0;
    obj_flat[63:0] = 64'h0F1E_2D3C_4B5A_6978;
    player = 4'b0001;
    lc = b_la_cyc;
    en_b = 1'b1;
    @(negedge clock);
    en_b = 1'b0;
    wait_fd_b(n);
    check("full_len", n + 1, 530);
    check("full_cnt", b_words.size(), 16);
    check("full_latch_cyc", b_la_cyc - lc, 16);
    for (int i = 0; i < 16; i++) check($sformatf("full_idx%0d", i), b_words[i][15:12], 32'(i));
    check("full_w0", b_words[0], {4'h0, obs_flat[3:0], obj_flat[3:0], player});
    check("full_w5", b_words[5], {4'h5, obs_flat[23:20], obj_flat[23:20], 4'h0});
    @(negedge clock);
    check("full_idle", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/map_matrix_driver.md
# map_matrix_driver

Renders the live game map onto an external LED matrix through a chain of serial-in/parallel-out shift registers. It sits directly downstream of the delivery-game datapath and consumes the flattened obstacle/objective maps and the player position that the datapath produces. Each frame it snapshots those inputs and streams the first ROWS map rows to the display as row-addressed 16-bit words, one latch pulse per row. Objectives blink, and game-over flashes the whole frame.

## Interface
- ROWS, 16: number of visible map rows scanned per frame (1..16); row r uses map bits [r*4 +: 4].
- CLK_DIV, 50: system clocks per serial-clock half period (≥1).
- BLINK_FRAMES, 8: frames per blink half-period (≥1).

- clock  in  1  system clock; everything is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; while high, frames run back-to-back.
- map_obstacles_flat  in  512  obstacle map, 4 lanes per row.
- map_objectives_flat  in  512  objective map, 4 lanes per row.
- player_position  in  4  one-hot player lane, drawn on row 0.
- game_over  in  1  game-over flag.
- sr_data  out  1  serial data, MSB first.
- sr_clock  out  1  serial shift clock; the external register samples on its rising edge.
- sr_latch  out  1  storage-register latch strobe.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- db_row  out  4  row currently being sent.

## Operation
- Row word, 16 bits: {row_index[3:0], obs[3:0], obj[3:0], ply[3:0]}.
  - obs and obj come from the snapshot at row r.
  - obj is forced to 0 when blink_phase=1.
  - ply is the snapshot player_position on row 0 and 0 on every other row.
- If the snapshot game_over=1 and blink_phase=1, all 12 pixel bits are 1. The row_index field is unchanged.
- The word is combinational from the snapshot, row and bit registers.
- States and transitions:
  - IDLE: all outputs 0. If enable=1, go to LOAD.
  - LOAD (1 cycle): register the snapshot of both maps, player_position and game_over. Set row=0 and bit=15. Go to SHIFT_LOW.
  - SHIFT_LOW (CLK_DIV cycles): sr_clock=0, sr_data=word[bit]. Go to SHIFT_HIGH.
  - SHIFT_HIGH (CLK_DIV cycles): sr_clock=1, sr_data is held.
    - If bit=0, go to LATCH.
    - Otherwise decrement bit and go to SHIFT_LOW.
  - LATCH (CLK_DIV cycles): sr_latch=1, sr_clock=0, sr_data=0.
    - If row=ROWS-1, go to DONE.
    - Otherwise increment row, set bit=15, go to SHIFT_LOW.
  - DONE (1 cycle): frame_done=1 and the blink counter advances.
    - If enable=1, go to LOAD; otherwise go to IDLE.
- Blink counter:
  - It counts 0..BLINK_FRAMES-1.
  - On wrap it returns to 0 and toggles blink_phase.
  - Reset value: counter 0, blink_phase 0.
- Inputs that change mid-frame are ignored until the next LOAD.
- Dropping enable mid-frame lets the current frame finish and reach DONE, then the block goes to IDLE.
- Asserting reset_n=0 at any point immediately drives all outputs to 0, sets the state to IDLE, and clears the snapshot, row, bit and blink registers. No partial latch pulse is emitted.

## Timing
- Reset values: sr_data=0, sr_clock=0, sr_latch=0, busy=0, frame_done=0, db_row=0.
- sr_data changes only on entry to SHIFT_LOW or LATCH, so it is stable for the CLK_DIV cycles before each sr_clock rising edge.
- Bit period is 2*CLK_DIV cycles.
- Row period is 33*CLK_DIV cycles: 16 bits plus CLK_DIV cycles of latch.
- Frame length, LOAD to DONE inclusive, is 2 + ROWS*33*CLK_DIV cycles.
- The first sr_clock rising edge occurs CLK_DIV+1 cycles after the LOAD cycle.
- When enable=1 in IDLE, LOAD occurs on the next cycle.
- With continuous enable, back-to-back frames are separated only by the DONE and LOAD cycles.
- frame_done is high for exactly one cycle per frame.
- sr_latch is high for exactly CLK_DIV cycles per row, ROWS times per frame.
- db_row equals the row register at all times.

## Test plan
- Basic frame, with ROWS=2, CLK_DIV=2:
  - Stimulus: obstacles row0=0010, row1=1000; objective row1=0001; player=0100; enable pulsed.
  - Required: serial words 16'h0204 then 16'h1810, MSB first, sampled on sr_clock rising edges.
  - Required: one sr_latch per word; frame_done at the 134th cycle counted from LOAD.
- Blink, with BLINK_FRAMES=1 and the same inputs, enable held:
  - Required: frame 2 row1 word is 16'h1800.
  - Required: frame 3 returns to 16'h1810.
- Game over, with BLINK_FRAMES=1 and game_over=1:
  - Required: frame 1 words are as in the basic case.
  - Required: frame 2 words are 16'h0FFF and 16'h1FFF.
- Snapshot isolation:
  - Stimulus: change map_obstacles_flat during row 0 shifting.
  - Required: the current frame is unchanged; the next frame shows the new value.
- Enable drop and reset:
  - Stimulus: drop enable mid-frame.
  - Required: the frame completes, frame_done pulses once, busy=0 on the next cycle.
  - Stimulus: assert reset_n=0 mid-shift.
  - Required: sr_data, sr_clock and sr_latch go to 0 and busy=0 with no clock edge; db_row=0.
- Full size, with ROWS=16 and CLK_DIV=1:
  - Required: 16 latch pulses with row_index fields 0..15.
  - Required: frame length 530 cycles.
